// File: rtl/binary_game_engine.sv
// Binary-conversion game engine: menu FSM, LFSR targets, timed Play rounds, practice mode, high score.
// Optional feature macro: BG_HINT_EN enables the Practice-mode higher/lower hint comparator.
module binary_game_engine #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned ROUNDS         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             Select,
  input  logic                             Quit,
  input  logic                             selectLeft,
  input  logic                             selectRight,
  input  logic [WIDTH-1:0]                 userNumber,
  output logic [WIDTH-1:0]                 outputNumber,
  output logic [$clog2(ROUNDS+1)-1:0]      score,
  output logic [$clog2(ROUNDS+1)-1:0]      highScore,
  output logic [$clog2(ROUNDS+1)-1:0]      round,
  output logic                             correct,
  output logic                             wrong,
  output logic [1:0]                       hint,
  output logic [9:0]                       q_State
);

  localparam int unsigned CW = $clog2(ROUNDS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [9:0] {
    S_INITIAL   = 10'b00_0000_0001,
    S_MENU      = 10'b00_0000_0010,
    S_PLAY_INIT = 10'b00_0000_0100,
    S_PLAY      = 10'b00_0000_1000,
    S_PLAY_DONE = 10'b00_0001_0000,
    S_PRAC_INIT = 10'b00_0010_0000,
    S_PRACTICE  = 10'b00_0100_0000,
    S_PRAC_DONE = 10'b00_1000_0000,
    S_SCORES    = 10'b01_0000_0000,
    S_DONE      = 10'b10_0000_0000
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cursor_q, cursor_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CW-1:0]     score_q, score_d;
  logic [CW-1:0]     round_q, round_d;
  logic [CW-1:0]     high_score_q, high_score_d;
  logic              correct_q, correct_d;
  logic              wrong_q, wrong_d;
  logic [WIDTH-1:0]  out_num_q, out_num_d;

  logic [WIDTH-1:0]  new_target;
  logic              hit;
  logic              play_hit;
  logic [CW-1:0]     round_inc;

  assign new_target = lfsr_q[WIDTH-1:0];
  assign hit        = (userNumber == target_q);
  assign play_hit   = Select && hit;
  assign round_inc  = round_q + CW'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_INITIAL;
      cursor_q     <= 2'd0;
      lfsr_q       <= SEED;
      target_q     <= '0;
      timer_q      <= '0;
      score_q      <= '0;
      round_q      <= '0;
      high_score_q <= '0;
      correct_q    <= 1'b0;
      wrong_q      <= 1'b0;
      out_num_q    <= '0;
    end else begin
      state_q      <= state_d;
      cursor_q     <= cursor_d;
      lfsr_q       <= lfsr_d;
      target_q     <= target_d;
      timer_q      <= timer_d;
      score_q      <= score_d;
      round_q      <= round_d;
      high_score_q <= high_score_d;
      correct_q    <= correct_d;
      wrong_q      <= wrong_d;
      out_num_q    <= out_num_d;
    end
  end

  // Next-state and datapath; Quit outranks Select, which outranks cursor moves.
  always_comb begin
    state_d      = state_q;
    cursor_d     = cursor_q;
    lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    target_d     = target_q;
    timer_d      = timer_q;
    score_d      = score_q;
    round_d      = round_q;
    high_score_d = high_score_q;
    correct_d    = 1'b0;
    wrong_d      = 1'b0;

    unique case (state_q)
      S_INITIAL: state_d = S_MENU;
      S_MENU: begin
        if (Quit) begin
          state_d = S_DONE;
        end else if (Select) begin
          unique case (cursor_q)
            2'd0:    state_d = S_PLAY_INIT;
            2'd1:    state_d = S_PRAC_INIT;
            2'd2:    state_d = S_SCORES;
            default: state_d = S_DONE;
          endcase
        end else if (selectLeft && !selectRight) begin
          cursor_d = cursor_q - 2'd1;
        end else if (selectRight && !selectLeft) begin
          cursor_d = cursor_q + 2'd1;
        end
      end
      S_PLAY_INIT: begin
        score_d  = '0;
        round_d  = '0;
        target_d = new_target;
        timer_d  = TIMER_LOAD;
        state_d  = S_PLAY;
      end
      S_PLAY: begin
        if (Quit) begin
          state_d      = S_PLAY_DONE;
          high_score_d = (score_q > high_score_q) ? score_q : high_score_q;
        end else if (Select || (timer_q == '0)) begin
          // A submit and a timeout in the same cycle resolve as a submit.
          correct_d = play_hit;
          wrong_d   = !play_hit;
          score_d   = score_q + CW'(play_hit);
          round_d   = round_inc;
          if (round_inc == CW'(ROUNDS)) begin
            state_d      = S_PLAY_DONE;
            high_score_d = (score_d > high_score_q) ? score_d : high_score_q;
          end else begin
            target_d = new_target;
            timer_d  = TIMER_LOAD;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_PRAC_INIT: begin
        target_d = new_target;
        state_d  = S_PRACTICE;
      end
      S_PRACTICE: begin
        if (Quit) begin
          state_d = S_PRAC_DONE;
        end else if (Select) begin
          correct_d = hit;
          wrong_d   = !hit;
          if (hit) target_d = new_target;
        end
      end
      S_PLAY_DONE, S_PRAC_DONE, S_SCORES: begin
        if (Quit || Select) state_d = S_MENU;
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_INITIAL;
    endcase

    unique case (state_d)
      S_PLAY, S_PRACTICE: out_num_d = target_d;
      S_SCORES:           out_num_d = WIDTH'(high_score_d);
      default:            out_num_d = '0;
    endcase
  end

`ifdef BG_HINT_EN
  // Higher/lower hint, only meaningful while practising.
  always_comb begin
    hint = 2'b00;
    if (state_q == S_PRACTICE) begin
      if (target_q > userNumber)      hint = 2'b01;
      else if (target_q < userNumber) hint = 2'b10;
    end
  end
`else
  assign hint = 2'b00;
`endif

  assign outputNumber = out_num_q;
  assign score        = score_q;
  assign highScore    = high_score_q;
  assign round        = round_q;
  assign correct      = correct_q;
  assign wrong        = wrong_q;
  assign q_State      = state_q;

endmodule

// File: tb/tb_binary_game_engine.sv
// Self-checking bench for binary_game_engine (ROUNDS=3, TIMEOUT_CYCLES=20): directed scenarios then random play.
module tb_binary_game_engine;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned ROUNDS = 3;
  localparam int unsigned TMO = 20;
  localparam int SEED_I = 'hACE1;

  localparam int ST_INIT = 0, ST_MENU = 1, ST_PINIT = 2, ST_PLAY = 3, ST_PDONE = 4,
                 ST_RINIT = 5, ST_PRAC = 6, ST_RDONE = 7, ST_SCORES = 8, ST_DONE = 9;

  logic             Clk;
  logic             Reset, Select, Quit, selectLeft, selectRight;
  logic [WIDTH-1:0] userNumber, outputNumber;
  logic [1:0]       score, highScore, round;
  logic             correct, wrong;
  logic [1:0]       practice_hint;
  logic [9:0]       q_State;

  binary_game_engine #(.WIDTH(WIDTH), .ROUNDS(ROUNDS), .TIMEOUT_CYCLES(TMO), .SEED(16'hACE1)) dut (
    .Clk(Clk), .Reset(Reset), .Select(Select), .Quit(Quit),
    .selectLeft(selectLeft), .selectRight(selectRight), .userNumber(userNumber),
    .outputNumber(outputNumber), .score(score), .highScore(highScore), .round(round),
    .correct(correct), .wrong(wrong), .hint(practice_hint), .q_State(q_State)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference game state
  int m_st, m_cur, m_lfsr, m_tgt, m_timer, m_score, m_round, m_hs, m_cor, m_wr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lfsr_step(input int v);
    return (v >> 1) ^ (((v & 1) != 0) ? 'hB400 : 0);
  endfunction

  function automatic int exp_out();
    if (m_st == ST_PLAY || m_st == ST_PRAC) return m_tgt;
    if (m_st == ST_SCORES) return m_hs;
    return 0;
  endfunction

  function automatic int exp_hint(input int user);
`ifdef BG_HINT_EN
    if (m_st != ST_PRAC) return 0;
    if (m_tgt > user) return 1;
    if (m_tgt < user) return 2;
    return 0;
`else
    return 0 * user;
`endif
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_step(input bit rst, input bit sel, input bit quit, input bit l, input bit r,
                            input int user);
    int fresh;
    bit ok;
    if (rst) begin
      m_st = ST_INIT; m_cur = 0; m_lfsr = SEED_I; m_tgt = 0; m_timer = 0;
      m_score = 0; m_round = 0; m_hs = 0; m_cor = 0; m_wr = 0;
      return;
    end
    fresh  = m_lfsr & 'hFF;
    m_lfsr = lfsr_step(m_lfsr);
    m_cor  = 0;
    m_wr   = 0;
    case (m_st)
      ST_INIT: m_st = ST_MENU;
      ST_MENU: begin
        if (quit) m_st = ST_DONE;
        else if (sel) m_st = (m_cur == 0) ? ST_PINIT : (m_cur == 1) ? ST_RINIT :
                             (m_cur == 2) ? ST_SCORES : ST_DONE;
        else if (l && !r) m_cur = (m_cur + 3) % 4;
        else if (r && !l) m_cur = (m_cur + 1) % 4;
      end
      ST_PINIT: begin
        m_score = 0; m_round = 0; m_tgt = fresh; m_timer = TMO - 1; m_st = ST_PLAY;
      end
      ST_PLAY: begin
        if (quit) begin
          m_st = ST_PDONE; m_hs = max2(m_hs, m_score);
        end else if (sel || m_timer == 0) begin
          ok = sel && (user == m_tgt);
          m_cor = ok ? 1 : 0;
          m_wr  = ok ? 0 : 1;
          m_score += m_cor;
          m_round += 1;
          if (m_round == ROUNDS) begin
            m_st = ST_PDONE; m_hs = max2(m_hs, m_score);
          end else begin
            m_tgt = fresh; m_timer = TMO - 1;
          end
        end else begin
          m_timer -= 1;
        end
      end
      ST_RINIT: begin m_tgt = fresh; m_st = ST_PRAC; end
      ST_PRAC: begin
        if (quit) m_st = ST_RDONE;
        else if (sel) begin
          if (user == m_tgt) begin m_cor = 1; m_tgt = fresh; end
          else m_wr = 1;
        end
      end
      ST_PDONE, ST_RDONE, ST_SCORES: if (quit || sel) m_st = ST_MENU;
      default: m_st = ST_DONE;
    endcase
  endtask

  task automatic compare_all();
    chk("q_State", 32'(q_State), 32'(1 << m_st));
    chk("outputNumber", 32'(outputNumber), 32'(exp_out()));
    chk("score", 32'(score), 32'(m_score));
    chk("highScore", 32'(highScore), 32'(m_hs));
    chk("round", 32'(round), 32'(m_round));
    chk("correct", 32'(correct), 32'(m_cor));
    chk("wrong", 32'(wrong), 32'(m_wr));
  endtask

  // One clock: drive inputs after negedge, step the model, compare at the next negedge.
  task automatic cyc(input bit rst, input bit sel, input bit quit, input bit l, input bit r,
                     input logic [7:0] user);
    Reset = rst; Select = sel; Quit = quit; selectLeft = l; selectRight = r; userNumber = user;
    #1;
    if (!rst) chk("practice_hint", 32'(practice_hint), 32'(exp_hint(int'(user))));
    model_step(rst, sel, quit, l, r, int'(user));
    @(negedge Clk);
    compare_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    int tgt;
    bit rst, sel, quit, l, r;
    logic [7:0] user;
    Reset = 1'b1; Select = 0; Quit = 0; selectLeft = 0; selectRight = 0; userNumber = '0;
    @(negedge Clk);

    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h00);
    chk("reset_state", 32'(q_State), 32'h001);
    idle();
    chk("menu_after_init", 32'(q_State), 32'h002);

    // Cursor wraps 0 -> 3 (Quit entry), then Done ignores everything but Reset
    cyc(0, 0, 0, 1, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("left_select_done", 32'(q_State), 32'h200);
    cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00);
    chk("done_sticky", 32'(q_State), 32'h200);

    // Three-round game: right, right, wrong
    cyc(1, 0, 0, 0, 0, 8'h00);
    idle();
    cyc(0, 1, 0, 0, 0, 8'h00);
    idle();
    cyc(0, 1, 0, 0, 0, 8'(m_tgt));
    chk("play_correct1", 32'(correct), 32'd1);
    cyc(0, 1, 0, 0, 0, 8'(m_tgt));
    cyc(0, 1, 0, 0, 0, 8'(m_tgt ^ 1));
    chk("game_score", 32'(score), 32'd2);
    chk("game_round", 32'(round), 32'd3);
    chk("game_high", 32'(highScore), 32'd2);
    chk("game_done_state", 32'(q_State), 32'h010);

    // Practice: wrong keeps the target, correct leaves score alone
    cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h00);
    idle();
    tgt = m_tgt;
    cyc(0, 1, 0, 0, 0, 8'(tgt ^ 5));
    chk("prac_wrong", 32'(wrong), 32'd1);
    chk("prac_target_kept", 32'(outputNumber), 32'(tgt));
    cyc(0, 1, 0, 0, 0, 8'(tgt));
    chk("prac_correct", 32'(correct), 32'd1);
    chk("prac_score_same", 32'(score), 32'd2);
    cyc(0, 0, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00);

    // Idle through a Play round until it times out
    cyc(0, 0, 0, 1, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h00);
    idle();
    repeat (TMO) idle();
    chk("timeout_wrong", 32'(wrong), 32'd1);
    chk("timeout_round", 32'(round), 32'd1);
    cyc(0, 0, 1, 0, 0, 8'h00);
    chk("quit_keeps_high", 32'(highScore), 32'd2);
    cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("scores_display", 32'(outputNumber), 32'd2);

    // Random play against the reference
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 199) == 0) || (m_st == ST_DONE && $urandom_range(0, 7) == 0);
      sel  = ($urandom_range(0, 3) == 0);
      quit = ($urandom_range(0, 15) == 0);
      l    = ($urandom_range(0, 3) == 0);
      r    = ($urandom_range(0, 3) == 0);
      user = ($urandom_range(0, 1) == 1) ? 8'(m_tgt) : 8'($urandom);
      cyc(rst, sel, quit, l, r, user);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
